// File: rtl/pl_sysref_pkg.sv
// rtl/pl_sysref_pkg.sv - shared types and constants for the PL SYSREF generator
package pl_sysref_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 8;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pl_sysref_phase_ctr.sv
// rtl/pl_sysref_phase_ctr.sv - free-running phase counter, 0..ld-1 then wrap
module pl_sysref_phase_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] ld,
  output logic [W-1:0] ph,
  output logic         wrap
);

  // >= rather than == so a period shrunk while idle cannot strand the count
  assign wrap = (ph >= (ld - W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if (wrap) begin
      ph <= '0;
    end else begin
      ph <= ph + W'(1);
    end
  end

endmodule

// File: rtl/pl_sysref_gen.sv
// rtl/pl_sysref_gen.sv - periodic / burst SYSREF pulse generator locked to a phase counter
module pl_sysref_gen
  import pl_sysref_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               pl_clk,
  input  logic               pl_resetn,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic               cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               sysref_out,
  output logic               sysref_rise,
  output logic               busy,
  output logic [15:0]        pulse_cnt,
  output logic               cfg_err
);

  state_t             state;
  logic [CNT_W-1:0]   per_q;
  logic [CNT_W-1:0]   hi_q;
  logic               mode_q;
  logic [BURST_W-1:0] n_q;

  logic [CNT_W-1:0]   ph;
  logic [CNT_W-1:0]   ph_nxt;
  logic               wrap;
  logic               hi_nxt;
  logic               cfg_ok;
  logic               burst_end;

  pl_sysref_phase_ctr #(.W(CNT_W)) u_phase (
    .clk   (pl_clk),
    .rst_n (pl_resetn),
    .ld    (per_q),
    .ph    (ph),
    .wrap  (wrap)
  );

  // Output is decided on the phase value the counter will hold after this edge
  assign ph_nxt = wrap ? '0 : ph + CNT_W'(1);
  assign hi_nxt = (ph_nxt < hi_q);

  assign cfg_ok = (cfg_period >= CNT_W'(2)) &&
                  (cfg_high != '0) &&
                  (cfg_high < cfg_period) &&
                  ((cfg_mode == MODE_CONT) || (cfg_burst != '0));

  assign burst_end = (mode_q == MODE_BURST) && sysref_out && !hi_nxt &&
                     (32'(pulse_cnt) == 32'(n_q));

  // Config tracks the inputs while idle and freezes once a start is accepted
  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      per_q  <= '0;
      hi_q   <= '0;
      mode_q <= MODE_CONT;
      n_q    <= '0;
    end else if (state == IDLE) begin
      per_q  <= cfg_period;
      hi_q   <= cfg_high;
      mode_q <= cfg_mode;
      n_q    <= cfg_burst;
    end
  end

  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      state       <= IDLE;
      sysref_out  <= 1'b0;
      sysref_rise <= 1'b0;
      busy        <= 1'b0;
      pulse_cnt   <= '0;
      cfg_err     <= 1'b0;
    end else begin
      sysref_rise <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_ok) begin
              state     <= ARM;
              busy      <= 1'b1;
              pulse_cnt <= '0;
              cfg_err   <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ARM: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            state       <= RUN;
            sysref_out  <= 1'b1;
            sysref_rise <= 1'b1;
            pulse_cnt   <= pulse_cnt + 16'd1;
          end
        end
        RUN: begin
          if (stop && (!sysref_out || !hi_nxt)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sysref_out <= 1'b0;
          end else if (stop) begin
            state <= DRAIN;
          end else if (burst_end) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sysref_out <= 1'b0;
          end else begin
            sysref_out <= hi_nxt;
            if (hi_nxt && !sysref_out) begin
              sysref_rise <= 1'b1;
              pulse_cnt   <= pulse_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (!hi_nxt) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sysref_out <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          sysref_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pl_sysref_gen.md
# pl_sysref_gen

Programmable SYSREF pulse generator in the PL clock domain: the transmit-side counterpart of PL SYSREF capture. It drives periodic (continuous) or counted-burst SYSREF pulses, phase-locked to a free-running period counter, toward the RF data converter and the differential output buffer. Pulses are never truncated; configuration is latched at start so the output period stays deterministic for multi-tile sync.

## Interface
- `CNT_W`, default 16: width of the period, high-time and phase counters.
- `BURST_W`, default 8: width of the burst pulse count.
- `pl_clk` in 1: PL clock (post-BUFGCE); all logic is on this one clock.
- `pl_resetn` in 1: reset, asynchronous assert, active-low.
- `cfg_period` in CNT_W: SYSREF period P in pl_clk cycles.
- `cfg_high` in CNT_W: high time H in cycles.
- `cfg_mode` in 1: 0 = continuous, 1 = burst of N pulses.
- `cfg_burst` in BURST_W: N, the pulse count for burst mode.
- `start` in 1: single-cycle request to begin generation.
- `stop` in 1: single-cycle request to end generation gracefully.
- `sysref_out` out 1: registered SYSREF output.
- `sysref_rise` out 1: one-cycle strobe, high in the same cycle `sysref_out` first goes high.
- `busy` out 1: high in states ARM, RUN and DRAIN.
- `pulse_cnt` out 16: pulses emitted since the last accepted start; wraps at 2^16.
- `cfg_err` out 1: sticky flag set when a start is rejected.

## Operation
- Reset values: every output is 0, state is IDLE, phase counter `ph` is 0, and the latched period `per_q` is set to `cfg_period` on the first clock after reset.
- Phase counter: free-running from 0 to `per_q`−1, then wraps to 0. In IDLE, `per_q`, `hi_q`, `mode_q` and `n_q` track the cfg inputs. Outside IDLE they are frozen.
- Validity check: P≥2, 1≤H≤P−1, and N≥1 when `cfg_mode`=1. A start with invalid config is ignored and sets `cfg_err`. A later valid start clears `cfg_err`.
- States:
  - IDLE: a valid `start` latches the config, clears `pulse_cnt` and moves to ARM. `start` and `stop` together in IDLE: stop wins and nothing happens.
  - ARM: on the cycle where `ph`=`per_q`−1, move to RUN. `stop` in ARM returns to IDLE with no pulse.
  - RUN: the output follows `sysref_out` = (`ph` < `hi_q`), evaluated on next-state values so the rising edge coincides with `ph` wrapping to 0. `pulse_cnt` increments on each rising edge.
    - Burst mode: when the Nth pulse's high time ends (`ph` reaches `hi_q` with `pulse_cnt`=N), go to IDLE.
    - `stop` while the output is low: go to IDLE immediately.
    - `stop` while the output is high: go to DRAIN.
  - DRAIN: hold the output high until `ph`=`hi_q`, then go to IDLE with the output low. No new rising edge is allowed.
- `start` while busy is ignored, with no `cfg_err`.
- Reset mid-pulse drops `sysref_out` to 0 asynchronously and returns to IDLE.

## Timing
- First rising edge of `sysref_out`: between 1 and P cycles after the start cycle, always aligned to `ph` = 0.
- Pulse shape: exactly H cycles high and P−H cycles low; rising edges are exactly P cycles apart.
- `sysref_rise` is aligned with the rising edge and lasts 1 cycle. `pulse_cnt` updates on the same edge.
- `busy` rises one cycle after an accepted start and falls on the edge where the state returns to IDLE.
- Burst end: `sysref_out` and `busy` fall on the same edge.
- No combinational path from any input to `sysref_out`.

## Structure
- Shared package `pl_sysref_pkg` holds:
  - the state enum (IDLE, ARM, RUN, DRAIN);
  - the mode constants `MODE_CONT`=0 and `MODE_BURST`=1;
  - the default `CNT_W` and `BURST_W`.
- One sub-module, `pl_sysref_phase_ctr`: the phase counter, with a parameterised width, an `ld` input for the period and outputs `ph` and `wrap`.
- The top level holds the FSM, the config latch, the validity check and the output registers.

## Test plan
- Continuous mode, P=16, H=4, start at an arbitrary phase: first rise within 16 cycles at `ph`=0; the pattern is 4 high and 12 low; `pulse_cnt` reads 10 after 10 periods.
- Burst mode, P=10, H=3, N=3: exactly 3 pulses with rises 10 cycles apart; `busy` and `sysref_out` fall together after the 3rd high; `pulse_cnt`=3.
- Stop during the 2nd high cycle (continuous, P=8, H=4): output stays high through cycle 4, then IDLE; no further rise.
- Invalid config (H=0, then P=1, then H=P=8): start is ignored, `cfg_err`=1, `busy`=0. A following valid start (P=8, H=2) clears `cfg_err` and runs.
- Simultaneous `start` and `stop` in IDLE: no state change. A second `start` in RUN with changed `cfg_period`: ignored, and the period is unchanged.
- Assert `pl_resetn`=0 mid-pulse: `sysref_out`, `busy` and `pulse_cnt` go to 0 immediately. After release the block stays IDLE until the next start.
